// File: rtl/seq_det_param_if.sv
// Serial receive-path bundle for seq_det_param: bit stream in, match status out.
// SEQ_DET_PROG_EN adds the run-time pattern load signals (and the SEQ_LEN parameter they need).
interface seq_det_param_if #(
    parameter int CNT_W = 8
`ifdef SEQ_DET_PROG_EN
    , parameter int SEQ_LEN = 4
`endif
);
    logic             din;
    logic             valid;
    logic             overlap;
    logic             clear;
    logic             seq_det;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;
`ifdef SEQ_DET_PROG_EN
    logic [SEQ_LEN-1:0] pat_in;
    logic               pat_load;

    modport master (output din, valid, overlap, clear, pat_in, pat_load,
                    input  seq_det, match_cnt, cnt_sat);
    modport slave  (input  din, valid, overlap, clear, pat_in, pat_load,
                    output seq_det, match_cnt, cnt_sat);
`else
    modport master (output din, valid, overlap, clear,
                    input  seq_det, match_cnt, cnt_sat);
    modport slave  (input  din, valid, overlap, clear,
                    output seq_det, match_cnt, cnt_sat);
`endif
endinterface

// File: rtl/seq_det_param.sv
// Parametrised Moore serial sequence detector with KMP fallback and saturating match counter.
// Optional run-time programmable pattern when SEQ_DET_PROG_EN is defined.
module seq_det_param #(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input logic          clk,
    input logic          rst,
    seq_det_param_if.slave bus
);
    localparam int               PW      = $clog2(SEQ_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Longest pattern prefix that is a suffix of (first p pattern bits, then b).
    function automatic int next_len(input logic [SEQ_LEN-1:0] pat, input int p, input logic b);
        int   res;
        int   idx;
        logic ok;
        logic sb;
        res = 0;
        for (int k = 1; k <= SEQ_LEN; k++) begin
            ok = (k <= p + 1);
            for (int j = 0; j < SEQ_LEN; j++) begin
                if (ok && j < k) begin
                    idx = p + 1 - k + j;
                    sb  = (idx < p) ? pat[SEQ_LEN-1-idx] : b;
                    if (pat[SEQ_LEN-1-j] != sb) ok = 1'b0;
                end
            end
            if (ok) res = k;
        end
        return res;
    endfunction

    // Longest proper prefix of the pattern that is also its suffix.
    function automatic int border_len(input logic [SEQ_LEN-1:0] pat);
        int   res;
        logic ok;
        res = 0;
        for (int k = 1; k < SEQ_LEN; k++) begin
            ok = 1'b1;
            for (int j = 0; j < SEQ_LEN - 1; j++)
                if (j < k && pat[SEQ_LEN-1-j] != pat[k-1-j]) ok = 1'b0;
            if (ok) res = k;
        end
        return res;
    endfunction

    logic [PW-1:0]    p_q;
    logic [PW-1:0]    p_adv;
    logic [PW-1:0]    fallback;
    logic             last_bit;
    logic             hit;
    logic             det_q;
    logic             sat_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;

`ifdef SEQ_DET_PROG_EN
    logic [SEQ_LEN-1:0] pat_q;

    assign p_adv    = PW'(next_len(pat_q, int'(p_q), bus.din));
    assign fallback = PW'(border_len(pat_q));
    assign last_bit = pat_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               pat_q <= PATTERN;
        else if (bus.pat_load) pat_q <= bus.pat_in;
    end
`else
    // Table entry (p, b) sits at index 2*p+b; the full-match entry is never used.
    function automatic logic [2*SEQ_LEN*PW-1:0] build_tab(input logic [SEQ_LEN-1:0] pat);
        logic [2*SEQ_LEN*PW-1:0] t;
        t = '0;
        for (int p = 0; p < SEQ_LEN; p++)
            for (int b = 0; b < 2; b++)
                t[(2*p+b)*PW +: PW] = PW'(next_len(pat, p, 1'(b)));
        return t;
    endfunction

    localparam logic [2*SEQ_LEN*PW-1:0] NEXT_TAB = build_tab(PATTERN);
    localparam logic [PW-1:0]           BORDER   = PW'(border_len(PATTERN));

    assign p_adv    = NEXT_TAB[(2*int'(p_q) + int'(bus.din))*PW +: PW];
    assign fallback = BORDER;
    assign last_bit = PATTERN[0];
`endif

    assign hit = (p_q == PW'(SEQ_LEN - 1)) && (bus.din == last_bit);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_inc = cnt_q;
        if (cnt_q != CNT_MAX) cnt_inc = cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q   <= '0;
            det_q <= 1'b0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            det_q <= 1'b0;
            if (bus.clear) begin
                p_q   <= '0;
                cnt_q <= '0;
                sat_q <= 1'b0;
            end
`ifdef SEQ_DET_PROG_EN
            else if (bus.pat_load) begin
                p_q <= '0;
            end
`endif
            else if (bus.valid) begin
                if (hit) begin
                    p_q   <= bus.overlap ? fallback : '0;
                    det_q <= 1'b1;
                    cnt_q <= cnt_inc;
                    sat_q <= (cnt_inc == CNT_MAX);
                end else begin
                    p_q <= p_adv;
                end
            end
        end
    end

    assign bus.seq_det   = det_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = sat_q;
endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: default-width and 2-bit-counter instances share one stimulus stream,
// checked against a sliding-window pattern model.
module tb_seq_det_param;
    localparam int         SEQ_LEN = 4;
    localparam logic [3:0] PAT     = 4'b1011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef SEQ_DET_PROG_EN
    seq_det_param_if #(.CNT_W(8), .SEQ_LEN(SEQ_LEN)) bus_a ();
    seq_det_param_if #(.CNT_W(2), .SEQ_LEN(SEQ_LEN)) bus_b ();
`else
    seq_det_param_if #(.CNT_W(8)) bus_a ();
    seq_det_param_if #(.CNT_W(2)) bus_b ();
`endif

    seq_det_param #(.SEQ_LEN(SEQ_LEN), .PATTERN(PAT), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    seq_det_param #(.SEQ_LEN(SEQ_LEN), .PATTERN(PAT), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int n_total = 0;
    int n_bad   = 0;

    bit         hist[$];
    logic       exp_det;
    logic [7:0] exp_cnt_a;
    logic [1:0] exp_cnt_b;

    logic [13:0] obs;
    assign obs = {bus_a.seq_det, bus_a.match_cnt, bus_a.cnt_sat,
                  bus_b.seq_det, bus_b.match_cnt, bus_b.cnt_sat};

    function automatic logic [13:0] exp_vec();
        return {exp_det, exp_cnt_a, exp_cnt_a == 8'hFF, exp_det, exp_cnt_b, exp_cnt_b == 2'b11};
    endfunction

    function automatic void model_reset();
        hist.delete();
        exp_det   = 1'b0;
        exp_cnt_a = '0;
        exp_cnt_b = '0;
    endfunction

    // A match is the last SEQ_LEN accepted bits equal to the pattern; non-overlap forgets them.
    function automatic void model_edge(input logic d, input logic v, input logic ov, input logic cl);
        bit hit;
        exp_det = 1'b0;
        if (cl) begin
            hist.delete();
            exp_cnt_a = '0;
            exp_cnt_b = '0;
        end else if (v) begin
            hist.push_back(d);
            if (hist.size() > SEQ_LEN) void'(hist.pop_front());
            hit = (hist.size() == SEQ_LEN);
            for (int i = 0; i < SEQ_LEN; i++)
                if (hit && hist[i] != PAT[SEQ_LEN-1-i]) hit = 1'b0;
            if (hit) begin
                exp_det = 1'b1;
                if (exp_cnt_a != 8'hFF) exp_cnt_a++;
                if (exp_cnt_b != 2'b11) exp_cnt_b++;
                if (!ov) hist.delete();
            end
        end
    endfunction

    task automatic set_inputs(input logic d, input logic v, input logic ov, input logic cl);
        bus_a.din = d; bus_a.valid = v; bus_a.overlap = ov; bus_a.clear = cl;
        bus_b.din = d; bus_b.valid = v; bus_b.overlap = ov; bus_b.clear = cl;
    endtask

    task automatic drive(input logic d, input logic v, input logic ov, input logic cl);
        @(negedge clk);
        set_inputs(d, v, ov, cl);
        @(posedge clk);
        #1;
        model_edge(d, v, ov, cl);
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_inputs(1'($urandom), 1'b1, 1'($urandom), 1'b0);
            @(posedge clk);
            #1;
            n_total++;
            if (obs !== 14'h0) begin
                n_bad++;
                $display("FAIL reset_hold cyc %0d: got=%h want=%h", i, obs, 14'h0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_detect_modes();
        logic [6:0] stream = 7'b1011011;
        int pulses;
        for (int ov = 0; ov < 2; ov++) begin
            do_reset();
            pulses = 0;
            for (int i = 6; i >= 0; i--) begin
                drive(stream[i], 1'b1, 1'(ov), 1'b0);
                pulses += int'(bus_a.seq_det);
                n_total++;
                if (obs !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL detect ov=%0d bit %0d: got=%h want=%h", ov, 7 - i, obs, exp_vec());
                end
            end
            n_total++;
            if (pulses != ov + 1 || bus_a.match_cnt !== 8'(ov + 1)) begin
                n_bad++;
                $display("FAIL detect_count ov=%0d: pulses=%0d cnt=%0d want=%0d", ov, pulses, bus_a.match_cnt, ov + 1);
            end
        end
    endtask

    task automatic test_mismatch();
        logic [4:0] stream = 5'b11011;
        int pulses;
        for (int ov = 0; ov < 2; ov++) begin
            do_reset();
            pulses = 0;
            for (int i = 4; i >= 0; i--) begin
                drive(stream[i], 1'b1, 1'(ov), 1'b0);
                pulses += int'(bus_a.seq_det);
                n_total++;
                if (obs !== exp_vec() || bus_a.seq_det !== (i == 0)) begin
                    n_bad++;
                    $display("FAIL mismatch ov=%0d bit %0d: got=%h want=%h", ov, 5 - i, obs, exp_vec());
                end
            end
            n_total++;
            if (pulses != 1) begin
                n_bad++;
                $display("FAIL mismatch_count ov=%0d: pulses=%0d want=1", ov, pulses);
            end
        end
    endtask

    task automatic test_gaps();
        int pulses = 0;
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            for (int g = 0; g < 3; g++) begin
                if (g == 0) drive(PAT[i], 1'b1, 1'b0, 1'b0);
                else        drive(1'(g), 1'b0, 1'b0, 1'b0);
                pulses += int'(bus_a.seq_det);
                n_total++;
                if (obs !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL gaps bit %0d gap %0d: got=%h want=%h", 4 - i, g, obs, exp_vec());
                end
            end
        end
        n_total++;
        if (pulses != 1) begin
            n_bad++;
            $display("FAIL gaps_count: pulses=%0d want=1", pulses);
        end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 3; i >= 0; i--) begin
                drive(PAT[i], 1'b1, 1'b1, 1'b0);
                pulses += int'(bus_b.seq_det);
                n_total++;
                if (obs !== exp_vec()) begin
                    n_bad++;
                    $display("FAIL saturation rep %0d bit %0d: got=%h want=%h", r, 4 - i, obs, exp_vec());
                end
            end
        end
        n_total++;
        if (pulses != 5 || bus_b.match_cnt !== 2'b11 || bus_b.cnt_sat !== 1'b1) begin
            n_bad++;
            $display("FAIL saturation_end: pulses=%0d cnt=%0d sat=%b want 5/3/1", pulses, bus_b.match_cnt, bus_b.cnt_sat);
        end
    endtask

    task automatic test_async_reset_clear();
        logic [3:0] pre  = 4'b1011;
        logic [2:0] part = 3'b101;
        do_reset();
        for (int i = 3; i >= 0; i--) drive(pre[i], 1'b1, 1'b0, 1'b0);
        for (int i = 2; i >= 0; i--) drive(part[i], 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_total++;
        if (obs !== 14'h0) begin
            n_bad++;
            $display("FAIL async_reset: got=%h want=%h", obs, 14'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        n_total++;
        if (obs !== exp_vec() || bus_a.seq_det !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_discard: got=%h want=%h", obs, exp_vec());
        end
        for (int i = 3; i >= 0; i--) begin
            drive(pre[i], 1'b1, 1'b0, 1'(i == 0));
            n_total++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL clear bit %0d: got=%h want=%h", 4 - i, obs, exp_vec());
            end
        end
        n_total++;
        if (bus_a.seq_det !== 1'b0 || bus_a.match_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL clear_end: det=%b cnt=%0d want 0/0", bus_a.seq_det, bus_a.match_cnt);
        end
        for (int i = 3; i >= 0; i--) begin
            drive(pre[i], 1'b1, 1'b0, 1'b0);
            n_total++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL after_clear bit %0d: got=%h want=%h", 4 - i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic d, v, ov, cl;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            d  = 1'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            ov = 1'($urandom);
            cl = ($urandom_range(0, 99) == 0);
            drive(d, v, ov, cl);
            n_total++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got=%h want=%h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SEQ_DET_PROG_EN
        bus_a.pat_load = 1'b0; bus_a.pat_in = PAT;
        bus_b.pat_load = 1'b0; bus_b.pat_in = PAT;
`endif
        model_reset();
        test_reset();
        test_detect_modes();
        test_mismatch();
        test_gaps();
        test_saturation();
        test_async_reset_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
